// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared encodings and widths for the microwave timer controller
package microwave_pkg;

   localparam int BCD_W      = 4;
   localparam int NUM_DIGITS = 4;
   localparam int BUF_W      = BCD_W * NUM_DIGITS;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_LOAD  = 3'd2,
      ST_COOK  = 3'd3,
      ST_PAUSE = 3'd4,
      ST_DONE  = 3'd5,
      ST_CLR   = 3'd6
   } state_t;

   function automatic logic is_bcd(input logic [BCD_W-1:0] d);
      return d <= BCD_W'(9);
   endfunction

endpackage

// File: rtl/bcd_entry_buf.sv
// rtl/bcd_entry_buf.sv - four-digit keypad shift buffer with cook-time validity check
module bcd_entry_buf
   import microwave_pkg::*;
(
   input  logic             clk,
   input  logic             clearn,
   input  logic             clear,
   input  logic             shift,
   input  logic             restart,
   input  logic [BCD_W-1:0] digit,
   output logic [BUF_W-1:0] value,
   output logic             valid
);

   always_ff @(posedge clk) begin
      if (!clearn || clear) begin
         value <= '0;
      end else if (shift) begin
         // restart begins a fresh entry so stale digits from a finished cook never leak in
         if (restart) begin
            value <= {{(BUF_W-BCD_W){1'b0}}, digit};
         end else begin
            value <= {value[BUF_W-BCD_W-1:0], digit};
         end
      end
   end

   always_comb begin
      valid = (value != '0) && (value[BCD_W +: BCD_W] <= BCD_W'(5));
   end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// rtl/microwave_timer_ctrl.sv - microwave cook-timer FSM; optional beep output under DONE_BEEP_EN
module microwave_timer_ctrl
   import microwave_pkg::*;
#(
   parameter int BEEP_TICKS = 3
) (
   input  logic             clk,
   input  logic             clearn,
   input  logic             tick,
   input  logic             key_valid,
   input  logic [BCD_W-1:0] key_digit,
   input  logic             start,
   input  logic             stop,
   input  logic             door_closed,
   input  logic             timer_zero,
   output logic [BUF_W-1:0] load_data,
   output logic             loadn,
   output logic             count_en,
   output logic             mag_on,
   output logic             done,
`ifdef DONE_BEEP_EN
   output logic             beep,
`endif
   output logic [2:0]       state
);

   state_t           state_q;
   state_t           state_d;
   logic [BUF_W-1:0] buf_value;
   logic             buf_valid;
   logic             buf_clear;
   logic             buf_shift;
   logic             buf_restart;
   logic             key_ok;

   // stop and start outrank a keypress arriving in the same cycle
   assign key_ok = key_valid && is_bcd(key_digit) && !stop && !start;

   bcd_entry_buf u_entry (
      .clk     (clk),
      .clearn  (clearn),
      .clear   (buf_clear),
      .shift   (buf_shift),
      .restart (buf_restart),
      .digit   (key_digit),
      .value   (buf_value),
      .valid   (buf_valid)
   );

   always_ff @(posedge clk) begin
      if (!clearn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      buf_clear   = 1'b0;
      buf_shift   = 1'b0;
      buf_restart = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (key_ok) begin
               buf_shift   = 1'b1;
               buf_restart = 1'b1;
               state_d     = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            if (stop) begin
               buf_clear = 1'b1;
               state_d   = ST_IDLE;
            end else if (start) begin
               if (door_closed && buf_valid) begin
                  state_d = ST_LOAD;
               end
            end else if (key_ok) begin
               buf_shift = 1'b1;
            end
         end
         ST_LOAD: state_d = ST_COOK;
         ST_COOK: begin
            if (stop || !door_closed) begin
               state_d = ST_PAUSE;
            end else if (timer_zero) begin
               state_d = ST_DONE;
            end
         end
         ST_PAUSE: begin
            if (stop) begin
               state_d = ST_CLR;
            end else if (start && door_closed) begin
               state_d = ST_COOK;
            end
         end
         ST_CLR: begin
            buf_clear = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_DONE: begin
            if (stop || start) begin
               buf_clear = 1'b1;
               state_d   = ST_IDLE;
            end else if (key_ok) begin
               buf_shift   = 1'b1;
               buf_restart = 1'b1;
               state_d     = ST_ENTRY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      loadn     = !((state_q == ST_LOAD) || (state_q == ST_CLR));
      load_data = (state_q == ST_CLR) ? '0 : buf_value;
      count_en  = (state_q == ST_COOK) && tick && !timer_zero;
      mag_on    = (state_q == ST_COOK);
      done      = (state_q == ST_DONE);
      state     = state_q;
   end

`ifdef DONE_BEEP_EN
   localparam int BEEP_CW = $clog2(BEEP_TICKS + 1);
   logic [BEEP_CW-1:0] beep_cnt;

   always_ff @(posedge clk) begin
      if (!clearn) begin
         beep     <= 1'b0;
         beep_cnt <= '0;
      end else if (state_q != ST_DONE && state_d == ST_DONE) begin
         beep     <= 1'b1;
         beep_cnt <= '0;
      end else if (state_d != ST_DONE) begin
         beep     <= 1'b0;
      end else if (beep && tick) begin
         if (beep_cnt == BEEP_CW'(BEEP_TICKS - 1)) begin
            beep <= 1'b0;
         end
         beep_cnt <= beep_cnt + 1'b1;
      end
   end
`else
   logic unused_beep_ticks;
   assign unused_beep_ticks = ^BEEP_TICKS;
`endif

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb/tb_microwave_timer_ctrl.sv - scoreboard bench with behavioural model and countdown environment
module tb_microwave_timer_ctrl;

   localparam int S_IDLE  = 0;
   localparam int S_ENTRY = 1;
   localparam int S_LOAD  = 2;
   localparam int S_COOK  = 3;
   localparam int S_PAUSE = 4;
   localparam int S_DONE  = 5;
   localparam int S_CLR   = 6;
   localparam int BEEPS   = 3;

   logic        clk = 1'b0;
   logic        clearn = 1'b0;
   logic        tick = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_digit = 4'd0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        door_closed = 1'b1;
   logic        timer_zero = 1'b1;
   logic [15:0] load_data;
   logic        loadn;
   logic        count_en;
   logic        mag_on;
   logic        done;
   logic        beep;
   logic [2:0]  state;

   always #5 clk = ~clk;

   microwave_timer_ctrl #(.BEEP_TICKS(BEEPS)) dut (
      .clk         (clk),
      .clearn      (clearn),
      .tick        (tick),
      .key_valid   (key_valid),
      .key_digit   (key_digit),
      .start       (start),
      .stop        (stop),
      .door_closed (door_closed),
      .timer_zero  (timer_zero),
      .load_data   (load_data),
      .loadn       (loadn),
      .count_en    (count_en),
      .mag_on      (mag_on),
      .done        (done),
`ifdef DONE_BEEP_EN
      .beep        (beep),
`endif
      .state       (state)
   );

`ifndef DONE_BEEP_EN
   assign beep = 1'b0;
`endif

   typedef struct {
      logic [2:0]  st;
      logic [15:0] ld;
      logic        ldn;
      logic        ce;
      logic        mag;
      logic        dn;
      logic        bp;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;

   int ms = S_IDLE;
   int dig[4] = '{0, 0, 0, 0};
   int beep_left = 0;
   int remain = 0;
   logic door_lvl = 1'b1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("state", 16'(state), 16'(e.st));
         check("load_data", load_data, e.ld);
         check("loadn", 16'(loadn), 16'(e.ldn));
         check("count_en", 16'(count_en), 16'(e.ce));
         check("mag_on", 16'(mag_on), 16'(e.mag));
         check("done", 16'(done), 16'(e.dn));
`ifdef DONE_BEEP_EN
         check("beep", 16'(beep), 16'(e.bp));
`endif
      end
   end

   function automatic logic [15:0] buf_val();
      return {dig[0][3:0], dig[1][3:0], dig[2][3:0], dig[3][3:0]};
   endfunction

   function automatic int to_secs(input logic [15:0] v);
      return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic void clear_digits();
      for (int i = 0; i < 4; i++) dig[i] = 0;
   endfunction

   function automatic void push_digit(input int d, input bit fresh);
      if (fresh) clear_digits();
      dig[0] = dig[1];
      dig[1] = dig[2];
      dig[2] = dig[3];
      dig[3] = d;
   endfunction

   // Advance environment counter and model across the clock edge using the inputs just sampled
   function automatic void model_step();
      int  prev;
      bit  kok;
      bit  entry_ok;
      if (!cur.ldn) remain = to_secs(cur.ld);
      else if (cur.ce && remain > 0) remain--;
      if (!clearn) begin
         ms = S_IDLE;
         clear_digits();
         beep_left = 0;
         return;
      end
      prev = ms;
      kok = key_valid && (key_digit <= 4'd9) && !stop && !start;
      entry_ok = (buf_val() != 16'h0) && (dig[2] <= 5);
      case (ms)
         S_IDLE:  if (kok) begin push_digit(int'(key_digit), 1'b1); ms = S_ENTRY; end
         S_ENTRY: begin
            if (stop) begin clear_digits(); ms = S_IDLE; end
            else if (start) begin if (door_closed && entry_ok) ms = S_LOAD; end
            else if (kok) push_digit(int'(key_digit), 1'b0);
         end
         S_LOAD:  ms = S_COOK;
         S_COOK:  begin
            if (stop || !door_closed) ms = S_PAUSE;
            else if (timer_zero) ms = S_DONE;
         end
         S_PAUSE: begin
            if (stop) ms = S_CLR;
            else if (start && door_closed) ms = S_COOK;
         end
         S_CLR:   begin clear_digits(); ms = S_IDLE; end
         S_DONE:  begin
            if (stop || start) begin clear_digits(); ms = S_IDLE; end
            else if (kok) begin push_digit(int'(key_digit), 1'b1); ms = S_ENTRY; end
         end
         default: ms = S_IDLE;
      endcase
      if (ms == S_DONE && prev != S_DONE) beep_left = BEEPS;
      else if (ms == S_DONE && tick && beep_left > 0) beep_left--;
      else if (ms != S_DONE) beep_left = 0;
   endfunction

   function automatic void expect_now();
      cur.st  = 3'(ms);
      cur.ldn = !(ms == S_LOAD || ms == S_CLR);
      cur.ld  = (ms == S_CLR) ? 16'h0 : buf_val();
      cur.ce  = (ms == S_COOK) && tick && !timer_zero;
      cur.mag = (ms == S_COOK);
      cur.dn  = (ms == S_DONE);
      cur.bp  = (ms == S_DONE) && (beep_left > 0);
   endfunction

   task automatic cyc(input logic kv, input logic [3:0] kd, input logic st, input logic sp,
                      input logic tk, input logic rn);
      @(posedge clk);
      model_step();
      #1;
      key_valid   = kv;
      key_digit   = kd;
      start       = st;
      stop        = sp;
      tick        = tk;
      clearn      = rn;
      door_closed = door_lvl;
      timer_zero  = (remain == 0);
      expect_now();
      q.push_back(cur);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic key(input logic [3:0] d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic press_start();
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic press_stop();
      cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic pulse_tick();
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      cur.st = 3'd0; cur.ld = 16'h0; cur.ldn = 1'b1; cur.ce = 1'b0;
      cur.mag = 1'b0; cur.dn = 1'b0; cur.bp = 1'b0;

      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);

      key(4'd1); key(4'd3); key(4'd0);
      press_start();
      idle(2);
      for (int i = 0; i < 5; i++) begin pulse_tick(); idle(1); end

      door_lvl = 1'b0;
      idle(1); pulse_tick(); idle(1);
      door_lvl = 1'b1;
      idle(1); press_start(); idle(1); pulse_tick();

      press_stop(); idle(1); press_stop(); idle(2);

      key(4'd9); key(4'd9); press_start(); idle(1);
      key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5); key(4'd12);
      press_start(); idle(1);
      press_stop(); idle(1);

      key(4'd3); press_start(); idle(2);
      for (int i = 0; i < 6; i++) begin pulse_tick(); idle(1); end
      for (int i = 0; i < 5; i++) begin pulse_tick(); idle(1); end
      key(4'd7); press_start(); idle(1);

      key(4'd2); key(4'd0); press_start(); idle(2); pulse_tick();
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         logic kv, st, sp, tk, rn;
         logic [3:0] kd;
         kv = ($urandom_range(0, 3) == 0);
         kd = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
         st = ($urandom_range(0, 5) == 0);
         sp = ($urandom_range(0, 24) == 0);
         tk = ($urandom_range(0, 1) == 0);
         rn = ($urandom_range(0, 299) != 0);
         door_lvl = ($urandom_range(0, 9) != 0);
         cyc(kv, kd, st, sp, tk, rn);
      end

      repeat (2) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
